// File: rtl/hazard_stall_unit.sv
// Load-use / memory-wait hazard detector: Mealy stall and bubble controls beside the ID/EX register,
// plus a sticky memory-wait timeout flag and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int LOAD_LAT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idValid,
  input  logic [2:0]  idSrc1,
  input  logic [2:0]  idSrc2,
  input  logic        idSrc1Used,
  input  logic        idSrc2Used,
  input  logic        exWb,
  input  logic [2:0]  exAddr,
  input  logic        exIsLoad,
  input  logic        memIsLoad,
  input  logic        memReady,
  input  logic        flush,
  output logic        stallFront,
  output logic        bubble,
  output logic        stallBack,
  output logic        timeoutErr,
  output logic [15:0] stallCycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] BUB_INIT = 3'(LOAD_LAT - 1);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] bub_cnt;
  logic [2:0] bub_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic [7:0] wait_inc;
  logic       err_set;
  logic       mem_wait;
  logic       load_use;
  logic       stall_front_c;
  logic       bubble_c;
  logic       stall_back_c;

  assign mem_wait = memIsLoad & ~memReady;
  assign load_use = idValid & ~flush & exWb & exIsLoad &
                    ((idSrc1Used & (idSrc1 == exAddr)) | (idSrc2Used & (idSrc2 == exAddr)));

  // First wait cycle from RUN loads 1; further waits count up and saturate.
  assign wait_inc = (state != MEM_WAIT) ? 8'd1 :
                    (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  always_comb begin
    stall_front_c = 1'b0;
    bubble_c      = 1'b0;
    stall_back_c  = 1'b0;
    state_nxt     = state;
    bub_nxt       = bub_cnt;
    wait_nxt      = wait_cnt;
    err_set       = 1'b0;
    case (state)
      LOAD_USE: begin
        if (mem_wait) begin
          stall_front_c = 1'b1;
          stall_back_c  = 1'b1;
        end else if (flush) begin
          state_nxt = RUN;
          bub_nxt   = 3'd0;
        end else begin
          stall_front_c = 1'b1;
          bubble_c      = 1'b1;
          bub_nxt       = bub_cnt - 3'd1;
          if (bub_cnt == 3'd1) begin
            state_nxt = RUN;
          end else begin
            state_nxt = LOAD_USE;
          end
        end
      end
      RUN, MEM_WAIT: begin
        if (mem_wait) begin
          stall_front_c = 1'b1;
          stall_back_c  = 1'b1;
          state_nxt     = MEM_WAIT;
          wait_nxt      = wait_inc;
          err_set       = (wait_inc == TIMEOUT_C);
        end else begin
          wait_nxt = 8'd0;
          if (load_use) begin
            stall_front_c = 1'b1;
            bubble_c      = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = LOAD_USE;
              bub_nxt   = BUB_INIT;
            end else begin
              state_nxt = RUN;
            end
          end else begin
            state_nxt = RUN;
          end
        end
      end
      default: begin
        state_nxt = RUN;
        bub_nxt   = 3'd0;
        wait_nxt  = 8'd0;
      end
    endcase
  end

  // Controls are combinational on the inputs but held inactive during reset.
  assign stallFront = rst_n & stall_front_c;
  assign bubble     = rst_n & bubble_c;
  assign stallBack  = rst_n & stall_back_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      bub_cnt     <= 3'd0;
      wait_cnt    <= 8'd0;
      timeoutErr  <= 1'b0;
      stallCycles <= 16'd0;
    end else begin
      state      <= state_nxt;
      bub_cnt    <= bub_nxt;
      wait_cnt   <= wait_nxt;
      timeoutErr <= timeoutErr | err_set;
      if (stall_front_c && (stallCycles != 16'hFFFF)) begin
        stallCycles <= stallCycles + 16'd1;
      end else begin
        stallCycles <= stallCycles;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: instance a uses LOAD_LAT=1/TIMEOUT=255,
// instance b uses LOAD_LAT=3/TIMEOUT=3; both share the same input stimulus.
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst_n;
  logic        idValid;
  logic [2:0]  idSrc1;
  logic [2:0]  idSrc2;
  logic        idSrc1Used;
  logic        idSrc2Used;
  logic        exWb;
  logic [2:0]  exAddr;
  logic        exIsLoad;
  logic        memIsLoad;
  logic        memReady;
  logic        flush;

  logic        sf_a, bub_a, sb_a, to_a;
  logic [15:0] cyc_a;
  logic        sf_b, bub_b, sb_b, to_b;
  logic [15:0] cyc_b;

  int errors = 0;
  int checks = 0;

  hazard_stall_unit #(.LOAD_LAT(1), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .idValid(idValid), .idSrc1(idSrc1), .idSrc2(idSrc2),
    .idSrc1Used(idSrc1Used), .idSrc2Used(idSrc2Used), .exWb(exWb), .exAddr(exAddr),
    .exIsLoad(exIsLoad), .memIsLoad(memIsLoad), .memReady(memReady), .flush(flush),
    .stallFront(sf_a), .bubble(bub_a), .stallBack(sb_a), .timeoutErr(to_a),
    .stallCycles(cyc_a)
  );

  hazard_stall_unit #(.LOAD_LAT(3), .TIMEOUT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .idValid(idValid), .idSrc1(idSrc1), .idSrc2(idSrc2),
    .idSrc1Used(idSrc1Used), .idSrc2Used(idSrc2Used), .exWb(exWb), .exAddr(exAddr),
    .exIsLoad(exIsLoad), .memIsLoad(memIsLoad), .memReady(memReady), .flush(flush),
    .stallFront(sf_b), .bubble(bub_b), .stallBack(sb_b), .timeoutErr(to_b),
    .stallCycles(cyc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs are then changed and sampled #1 later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; idValid = 1'b0; idSrc1 = 3'd0; idSrc2 = 3'd0;
    idSrc1Used = 1'b0; idSrc2Used = 1'b0; exWb = 1'b0; exAddr = 3'd0;
    exIsLoad = 1'b0; memIsLoad = 1'b1; memReady = 1'b0; flush = 1'b0;

    // Reset with a memory wait present: controls must stay forced low.
    next_cycle(); next_cycle(); #1;
    chk1("rst_sf", sf_a, 1'b0);
    chk1("rst_sb", sb_a, 1'b0);
    chk16("rst_cycles", cyc_a, 16'd0);
    chk1("rst_timeout", to_a, 1'b0);

    // Test 1/2: load-use on src1.
    next_cycle();
    rst_n = 1'b1; memIsLoad = 1'b0;
    idValid = 1'b1; exWb = 1'b1; exIsLoad = 1'b1; exAddr = 3'd5; idSrc1 = 3'd5; idSrc1Used = 1'b1;
    #1;
    chk1("lu_sf_a", sf_a, 1'b1);
    chk1("lu_bub_a", bub_a, 1'b1);
    chk1("lu_sb_a", sb_a, 1'b0);
    chk1("lu_bub_b", bub_b, 1'b1);
    next_cycle();
    exWb = 1'b0; exIsLoad = 1'b0;
    #1;
    chk1("lu_end_sf_a", sf_a, 1'b0);
    chk1("lu_end_bub_a", bub_a, 1'b0);
    chk16("lu_cycles_a", cyc_a, 16'd1);
    chk1("lu2_bub_b", bub_b, 1'b1);
    chk1("lu2_sf_b", sf_b, 1'b1);
    next_cycle(); #1;
    chk1("lu3_bub_b", bub_b, 1'b1);
    next_cycle(); #1;
    chk1("lu4_sf_b", sf_b, 1'b0);
    chk1("lu4_bub_b", bub_b, 1'b0);
    chk16("lu_cycles_b", cyc_b, 16'd3);

    // Test 3: near-misses produce no stall.
    next_cycle();
    exWb = 1'b1; exIsLoad = 1'b1; idSrc1Used = 1'b0;
    #1;
    chk1("nouse_sf", sf_a, 1'b0);
    next_cycle();
    idSrc1Used = 1'b1; exIsLoad = 1'b0;
    #1;
    chk1("noload_sf", sf_a, 1'b0);
    next_cycle();
    exIsLoad = 1'b1; flush = 1'b1;
    #1;
    chk1("flush_sf", sf_a, 1'b0);
    chk1("flush_bub", bub_a, 1'b0);
    next_cycle();
    flush = 1'b0; idSrc1Used = 1'b0; idSrc2Used = 1'b1; idSrc2 = 3'd5; idSrc1 = 3'd2;
    #1;
    chk1("src2_bub", bub_a, 1'b1);
    chk1("src2_sb", sb_a, 1'b0);
    next_cycle();
    idValid = 1'b0; exWb = 1'b0; exIsLoad = 1'b0; idSrc2Used = 1'b0;
    next_cycle(); next_cycle(); next_cycle(); #1;
    chk16("idle_cycles_a", cyc_a, 16'd2);

    // Test 4/5: five memory wait cycles, then ready.
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      memIsLoad = 1'b1; memReady = 1'b0;
      #1;
      chk1("wait_sf_a", sf_a, 1'b1);
      chk1("wait_sb_a", sb_a, 1'b1);
      chk1("wait_bub_a", bub_a, 1'b0);
      chk1("wait_to_b", to_b, (k >= 4) ? 1'b1 : 1'b0);
    end
    next_cycle();
    memReady = 1'b1;
    #1;
    chk1("ready_sf_a", sf_a, 1'b0);
    chk1("ready_sb_a", sb_a, 1'b0);
    chk1("ready_to_a", to_a, 1'b0);
    chk1("ready_to_b", to_b, 1'b1);
    next_cycle();
    memIsLoad = 1'b0; memReady = 1'b0;
    #1;
    chk1("sticky_to_b", to_b, 1'b1);
    chk16("wait_cycles_a", cyc_a, 16'd7);

    // Test 6: memWait and loadUse together, then release with loadUse persisting.
    next_cycle();
    memIsLoad = 1'b1; memReady = 1'b0;
    idValid = 1'b1; exWb = 1'b1; exIsLoad = 1'b1; exAddr = 3'd5; idSrc1 = 3'd5; idSrc1Used = 1'b1;
    #1;
    chk1("both_sb_a", sb_a, 1'b1);
    chk1("both_bub_a", bub_a, 1'b0);
    chk1("both_sf_a", sf_a, 1'b1);
    next_cycle();
    memReady = 1'b1;
    #1;
    chk1("rel_bub_a", bub_a, 1'b1);
    chk1("rel_sb_a", sb_a, 1'b0);
    chk1("rel_bub_b", bub_b, 1'b1);
    next_cycle();
    memIsLoad = 1'b0; memReady = 1'b0; idValid = 1'b0; exWb = 1'b0; exIsLoad = 1'b0;
    #1;
    chk1("lus_bub_b", bub_b, 1'b1);
    chk1("lus_sf_a", sf_a, 1'b0);
    next_cycle();
    memIsLoad = 1'b1;
    #1;
    chk1("lus_wait_sb_b", sb_b, 1'b1);
    chk1("lus_wait_bub_b", bub_b, 1'b0);
    chk1("lus_wait_sf_b", sf_b, 1'b1);
    next_cycle();
    memIsLoad = 1'b0; rst_n = 1'b0;
    #1;
    chk16("pre_rst_cycles_a", cyc_a, 16'd10);
    chk1("in_rst_sf_b", sf_b, 1'b0);
    chk1("in_rst_bub_b", bub_b, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk1("post_rst_sf_b", sf_b, 1'b0);
    chk1("post_rst_bub_b", bub_b, 1'b0);
    chk1("post_rst_to_b", to_b, 1'b0);
    chk16("post_rst_cycles_b", cyc_b, 16'd0);
    chk16("post_rst_cycles_a", cyc_a, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
